// File: rtl/dfr_reservoir.sv
// Multi-bit delayed-feedback reservoir: each accepted sample is spread over
// VIRTUAL_NODES virtual nodes, one node per cycle, through a delay line.
module dfr_reservoir #(
  parameter int          DATA_WIDTH    = 16,
  parameter int          VIRTUAL_NODES = 10,
  parameter logic [15:0] MASK_SEED     = 16'hACE1,
  parameter int          IDX_W         = $clog2(VIRTUAL_NODES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic                         din_ready,
  input  logic [1:0]                   mode,
  input  logic [2:0]                   fb_shift,
  output logic                         dout_valid,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic [IDX_W-1:0]             dout_idx,
  output logic                         dout_last
);

  // state  | meaning
  // S_INIT | zero one delay-line entry per cycle after reset
  // S_IDLE | ready, waiting for a sample
  // S_RUN  | compute and emit node r_k of the latched sample
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VIRTUAL_NODES - 1);
  localparam logic signed [DATA_WIDTH-1:0] MAX_V  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] MIN_V  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] CLIP_P = {2'b01, {(DATA_WIDTH-2){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] CLIP_N = {2'b11, {(DATA_WIDTH-2){1'b0}}};

  state_t                       r_state, w_state_nxt;
  logic [IDX_W-1:0]             r_k, w_k_nxt;
  logic [15:0]                  r_lfsr, w_lfsr_nxt;
  logic signed [DATA_WIDTH-1:0] r_u;
  logic [1:0]                   r_mode;
  logic [2:0]                   r_shift;
  logic signed [DATA_WIDTH-1:0] r_line [VIRTUAL_NODES];

  logic                         w_accept;
  logic                         w_node_en;
  logic                         w_wr_en;
  logic signed [DATA_WIDTH-1:0] w_wr_data;
  logic                         w_lfsr_fb;
  logic signed [DATA_WIDTH-1:0] w_x_old;
  logic signed [DATA_WIDTH-1:0] w_neg_u;
  logic signed [DATA_WIDTH-1:0] w_term_u;
  logic signed [DATA_WIDTH-1:0] w_fb;
  logic signed [DATA_WIDTH:0]   w_sum;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic signed [DATA_WIDTH-1:0] w_nl;

  assign din_ready = (r_state == S_IDLE);
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Node datapath; the delay-line entry is read combinationally before its write
  always_comb begin
    w_x_old  = r_line[r_k];
    w_neg_u  = (r_u == MIN_V) ? MAX_V : -r_u;
    w_term_u = r_lfsr[0] ? r_u : w_neg_u;
    w_fb     = w_x_old >>> r_shift;
    w_sum    = {w_term_u[DATA_WIDTH-1], w_term_u} + {w_fb[DATA_WIDTH-1], w_fb};
    if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
      w_sat = w_sum[DATA_WIDTH] ? MIN_V : MAX_V;
    end else begin
      w_sat = w_sum[DATA_WIDTH-1:0];
    end
    w_nl = w_sat;
    case (r_mode)
      2'd1: w_nl = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
      2'd2: begin
        if (w_sat > CLIP_P) begin
          w_nl = CLIP_P;
        end else if (w_sat < CLIP_N) begin
          w_nl = CLIP_N;
        end
      end
      default: w_nl = w_sat;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_lfsr_nxt  = r_lfsr;
    w_accept    = 1'b0;
    w_node_en   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    case (r_state)
      S_INIT: begin
        w_wr_en = 1'b1;
        if (r_k == LAST_IDX) begin
          w_k_nxt     = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_k_nxt = r_k + IDX_W'(1);
        end
      end
      S_IDLE: begin
        if (din_valid) begin
          w_accept    = 1'b1;
          w_lfsr_nxt  = MASK_SEED;
          w_k_nxt     = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_node_en  = 1'b1;
        w_wr_en    = 1'b1;
        w_wr_data  = w_nl;
        w_lfsr_nxt = {w_lfsr_fb, r_lfsr[15:1]};
        if (r_k == LAST_IDX) begin
          w_k_nxt     = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_k_nxt = r_k + IDX_W'(1);
        end
      end
      default: begin
        w_k_nxt     = '0;
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_k     <= '0;
      r_lfsr  <= MASK_SEED;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_u        <= '0;
      r_mode     <= '0;
      r_shift    <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_idx   <= '0;
      dout_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_u     <= din;
        r_mode  <= mode;
        r_shift <= fb_shift;
      end
      dout_valid <= w_node_en;
      if (w_node_en) begin
        dout      <= w_nl;
        dout_idx  <= r_k;
        dout_last <= (r_k == LAST_IDX);
      end
    end
  end

  // Delay line has no reset; the INIT pass clears it
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      r_line[r_k] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_dfr_reservoir.sv
// Randomised bench for dfr_reservoir against an arithmetic reference model
// of the reservoir (per-node values, index, last flag and output cycle).
module tb_dfr_reservoir;

  localparam int DW   = 16;
  localparam int N    = 10;
  localparam int IW   = 4;
  localparam int SEED = 'hACE1;
  localparam int MAXV = 32767;
  localparam int MINV = -32768;

  logic                 clk;
  logic                 rst;
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic                 din_ready;
  logic [1:0]           mode;
  logic [2:0]           fb_shift;
  logic                 dout_valid;
  logic signed [DW-1:0] dout;
  logic [IW-1:0]        dout_idx;
  logic                 dout_last;

  dfr_reservoir #(.DATA_WIDTH(DW), .VIRTUAL_NODES(N), .MASK_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .mode       (mode),
    .fb_shift   (fb_shift),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .dout_last  (dout_last)
  );

  typedef struct {
    int val;
    int idx;
    int last;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   x_ref [N];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_t = 0;
  int   prev_t = 0;
  int   obs_n0 = 0;
  bit   acc_ok;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: nodes computed from the reservoir equations with plain integers
  task automatic model_push(input int u, input int md, input int sh, input int t0);
    int l, m, nu, tt, s, b;
    l = SEED;
    for (int k = 0; k < N; k++) begin
      m  = l & 1;
      nu = (u == MINV) ? MAXV : -u;
      tt = (m != 0) ? u : nu;
      s  = tt + (x_ref[k] >>> sh);
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      if (md == 1 && s < 0) s = 0;
      if (md == 2) begin
        if (s > 16384) s = 16384;
        if (s < -16384) s = -16384;
      end
      x_ref[k] = s;
      q.push_back('{val: s, idx: k, last: (k == N-1) ? 1 : 0, cyc: t0 + 2 + k});
      b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      l = (l >> 1) | (b << 15);
    end
  endtask

  always @(negedge clk) begin
    if (dout_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("dout", int'(dout), mon_e.val);
        check("dout_idx", int'(dout_idx), mon_e.idx);
        check("dout_last", int'(dout_last), mon_e.last);
        check("out_cycle", cyc, mon_e.cyc);
        if (mon_e.idx == 0) obs_n0 = int'(dout);
      end
    end
  end

  task automatic send(input int u, input int md, input int sh, input bit hold);
    logic signed [DW-1:0] v;
    v = DW'(u);
    acc_ok = 1'b0;
    @(posedge clk);
    #1;
    din       = v;
    mode      = 2'(md);
    fb_shift  = 3'(sh);
    din_valid = 1'b1;
    for (int i = 0; i < 4*N; i++) begin
      @(negedge clk);
      if (din_ready) begin
        acc_ok = 1'b1;
        break;
      end
    end
    if (!acc_ok) begin
      check("ready_timeout", 0, 1);
      din_valid = 1'b0;
    end else begin
      prev_t = last_t;
      last_t = cyc;
      model_push(int'(v), md, sh, last_t);
      @(posedge clk);
      #1;
      if (!hold) din_valid = 1'b0;
      mode     = 2'($urandom_range(0, 3));
      fb_shift = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4*N && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic check_init(input string tag, input bit check_abort);
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      check(tag, int'(din_ready), (i == N) ? 1 : 0);
      if (i == 0 && check_abort) check("abort_valid", int'(dout_valid), 0);
    end
  endtask

  initial begin
    int u, sel;
    logic signed [DW-1:0] rv;
    rst = 1'b1; din_valid = 1'b0; din = '0; mode = '0; fb_shift = '0;
    for (int k = 0; k < N; k++) x_ref[k] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", int'(din_ready), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_idx", int'(dout_idx), 0);
    check("rst_last", int'(dout_last), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_init("init_ready", 1'b0);
    check("init_dout", int'(dout), 0);

    send(100, 0, 0, 1'b0);
    drain();
    check("node0_plus100", obs_n0, 100);
    send(0, 0, 1, 1'b0);
    drain();

    send(32767, 0, 0, 1'b0);
    send(32767, 0, 0, 1'b0);
    send(-20000, 1, 0, 1'b0);
    send(30000, 2, 0, 1'b0);
    send(-32768, 0, 2, 1'b0);
    send(-32768, 2, 0, 1'b0);
    drain();

    for (int i = 0; i < 5; i++) begin
      send(1000 + i, 0, 1, 1'b1);
      if (i > 0) check("accept_gap", last_t - prev_t, N + 1);
    end
    din_valid = 1'b0;
    drain();

    send(123, 0, 0, 1'b0);
    while (cyc < last_t + 6) @(negedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    for (int k = 0; k < N; k++) x_ref[k] = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_init("reinit_ready", 1'b1);
    send(0, $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      rv  = DW'($urandom);
      u   = (sel == 0) ? MINV : (sel == 1) ? MAXV : int'(rv);
      send(u, $urandom_range(0, 3), $urandom_range(0, 7), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dfr_reservoir.md
# dfr_reservoir

Parametrised, multi-bit delayed-feedback reservoir and successor to the 1-bit `reservoir`. Each accepted input sample is time-multiplexed across `VIRTUAL_NODES` virtual nodes:
- each node value is a masked copy of the input plus a scaled copy of the same node from the previous sample;
- the sum passes through a selectable nonlinearity;
- one node value is emitted per cycle.

The block sits between the input sample source and the readout layer of the hybrid DFR system.

## Interface
- `DATA_WIDTH`, 16, signed two's-complement width of input, node state and output.
- `VIRTUAL_NODES`, 10, delay-line length (number of virtual nodes); legal range 2..1024.
- `MASK_SEED`, 16'hACE1, nonzero seed of the input-mask LFSR.
- `IDX_W`, $clog2(VIRTUAL_NODES), width of the node index output.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din_valid` in 1: input sample valid.
- `din` in DATA_WIDTH: signed input sample u.
- `din_ready` out 1: block can accept a sample.
- `mode` in 2: nonlinearity select, latched on accept. 0 = linear saturate, 1 = ReLU, 2 = hard-tanh, 3 = same as 0.
- `fb_shift` in 3: feedback gain 2^-fb_shift, latched on accept.
- `dout_valid` out 1: node output valid.
- `dout` out DATA_WIDTH: signed node value.
- `dout_idx` out IDX_W: node index of `dout`.
- `dout_last` out 1: high with the final node (idx VIRTUAL_NODES-1) of a sample.

## Operation
FSM states: INIT, IDLE, RUN.
- INIT:
  - entered on `rst`.
  - Writes 0 to every delay-line entry, one per cycle, for VIRTUAL_NODES cycles, then goes to IDLE.
  - `din_ready` is 0.
- IDLE:
  - `din_ready` = 1.
  - On `din_valid`, the block latches `din`, `mode` and `fb_shift`, reloads the LFSR to MASK_SEED, sets node counter k = 0 and goes to RUN.
- RUN:
  - One node per cycle, k = 0..VIRTUAL_NODES-1. For node k:
    - m = LFSR[0].
    - s = (m ? u : -u) + (x_old[k] >>> fb_shift), computed in DATA_WIDTH+1 bits.
    - s saturates to the DATA_WIDTH signed range.
    - x_new = NL(s).
  - The delay-line entry k is read before it is written (read-before-write on the same entry in the same cycle). x_new is written back to it.
  - The LFSR advances once per node: 16-bit Fibonacci, taps 16,14,13,11, shift right, new bit into [15].
  - After k = VIRTUAL_NODES-1 the block returns to IDLE; the node counter wraps to 0.
- Arithmetic rules:
  - -u of the most negative value saturates to the maximum positive value.
  - `>>>` is an arithmetic shift.
- Nonlinearity NL:
  - mode 0: identity (s is already saturated).
  - mode 1: max(s, 0).
  - mode 2: clip s to ±2^(DATA_WIDTH-2), i.e. ±16384 at width 16.
- Outputs are registered. `dout`, `dout_idx` and `dout_last` hold their last value when `dout_valid` = 0.
- No backpressure on the output: the consumer must accept every valid output.

## Timing
- Reset values: `din_ready` 0, `dout_valid` 0, `dout` 0, `dout_idx` 0, `dout_last` 0. FSM state is INIT, LFSR = MASK_SEED, node counter 0.
- `rst` held for one or more cycles, then deasserted at cycle r: INIT occupies cycles r..r+VIRTUAL_NODES-1, and `din_ready` is first 1 at cycle r+VIRTUAL_NODES.
- A sample accepted at cycle t (`din_valid` & `din_ready`):
  - RUN covers cycles t+1..t+VIRTUAL_NODES.
  - Node k appears with `dout_valid` = 1 at cycle t+2+k.
  - `dout_last` is asserted at cycle t+1+VIRTUAL_NODES.
- `din_ready` is low during t+1..t+VIRTUAL_NODES. The next sample can be accepted at t+VIRTUAL_NODES+1, so the sustained rate is one sample per VIRTUAL_NODES+1 cycles.
- Changes to `mode`/`fb_shift` during RUN have no effect until the next accept.
- `rst` during RUN or INIT:
  - aborts the current sample;
  - `dout_valid` is 0 from the next cycle;
  - the block re-enters INIT, so the full zeroing pass repeats and no partial-sample state survives.
- `din_valid` while `din_ready` = 0 is ignored. The source must hold the sample until it is accepted.

## Test plan
- Reset/init: `rst` for 3 cycles, then release → `din_ready` stays 0 for exactly 10 cycles and rises on the 11th; all outputs stay 0.
- Single sample: mode 0, `fb_shift` 0, `din` = 100 after reset → 10 outputs with idx 0..9, `dout_last` only on idx 9; node 0 = +100 (ACE1 bit0 = 1); each node = ±100 per the LFSR reference model.
- Feedback: the sample above, then `din` = 0 with `fb_shift` = 1 → each node = previous node value >>> 1 (±50).
- Saturation/NL:
  - `din` = 32767 twice, `fb_shift` 0, mode 0 → nodes with m = 1 output 32767 on the second sample.
  - mode 1 → all negative nodes output 0.
  - mode 2 → no output exceeds ±16384.
- Handshake: `din_valid` held high with incrementing `din` → accepts spaced exactly 11 cycles apart, no sample dropped or duplicated.
- Reset mid-RUN: assert `rst` at node 4 → `dout_valid` 0 next cycle; after INIT, a `din` = 0 sample yields all-zero outputs.
